// File: rtl/fib_lookup_arb_pkg.sv
// Shared bridge constants and helpers for the FIB lookup arbiter.
package fib_lookup_arb_pkg;

  localparam int unsigned NUM_PORTS  = 4;
  localparam int unsigned FIB_KEY_SZ = 48;
  localparam int unsigned PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef logic [PORT_W-1:0]    port_id_t;
  typedef logic [NUM_PORTS-1:0] port_mask_t;

  // Cyclic successor of a port index.
  function automatic port_id_t next_port(input port_id_t p);
    if (32'(p) + 32'd1 >= NUM_PORTS) return '0;
    return p + PORT_W'(1);
  endfunction

  function automatic port_mask_t port_bit(input port_id_t p);
    return NUM_PORTS'(1) << p;
  endfunction

endpackage

// File: rtl/fib_lookup_arb_if.sv
// Request, engine and fli channels of the FIB lookup arbiter.
interface fib_lookup_arb_if
  import fib_lookup_arb_pkg::*;
#(
  parameter int unsigned key_sz = FIB_KEY_SZ
) ();

  logic [NUM_PORTS-1:0]        lrq_srdy;
  logic [NUM_PORTS-1:0]        lrq_drdy;
  logic [NUM_PORTS*key_sz-1:0] lrq_data;
  logic                        eng_req_srdy;
  logic                        eng_req_drdy;
  logic [key_sz-1:0]           eng_req_data;
  logic                        eng_rsp_srdy;
  logic                        eng_rsp_drdy;
  logic [NUM_PORTS-1:0]        eng_rsp_data;
  logic [NUM_PORTS-1:0]        fli_srdy;
  logic [NUM_PORTS-1:0]        fli_drdy;
  logic [NUM_PORTS-1:0]        fli_data;
  logic                        err_orphan;

  // Arbiter side.
  modport slave (
    input  lrq_srdy, lrq_data, eng_req_drdy, eng_rsp_srdy, eng_rsp_data, fli_drdy,
    output lrq_drdy, eng_req_srdy, eng_req_data, eng_rsp_drdy, fli_srdy, fli_data,
           err_orphan
  );

  // Ports, engine and taps side.
  modport master (
    output lrq_srdy, lrq_data, eng_req_drdy, eng_rsp_srdy, eng_rsp_data, fli_drdy,
    input  lrq_drdy, eng_req_srdy, eng_req_data, eng_rsp_drdy, fli_srdy, fli_data,
           err_orphan
  );

endinterface

// File: rtl/fib_arb_tagq.sv
// In-order requester tag FIFO; full/empty derived purely from the registered count.
module fib_arb_tagq #(
  parameter int unsigned width = 2,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(depth);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CNT_W'(depth));
  assign empty    = (cnt_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fib_lookup_arb.sv
// Round-robin sharing of one FIB lookup engine among the port taps, with
// in-order response steering back to the requesting tap.
module fib_lookup_arb
  import fib_lookup_arb_pkg::*;
#(
  parameter int unsigned key_sz     = FIB_KEY_SZ,
  parameter int unsigned tagq_depth = 4,
  parameter bit          mask_src   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  fib_lookup_arb_if.slave    bus
);

  port_id_t rr_q, rr_d;
  logic     err_orphan_q, err_orphan_d;
  port_id_t grant;
  port_id_t cand;
  logic     any_req;
  logic     tq_push, tq_pop, tq_full, tq_empty;
  port_id_t head;

  fib_arb_tagq #(
    .width (PORT_W),
    .depth (tagq_depth)
  ) u_tagq (
    .clk       (clk),
    .reset     (reset),
    .push      (tq_push),
    .push_data (grant),
    .pop       (tq_pop),
    .pop_data  (head),
    .full      (tq_full),
    .empty     (tq_empty)
  );

  // First requester at or after rr, cyclically.
  always_comb begin
    grant   = rr_q;
    cand    = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = PORT_W'((32'(rr_q) + i) % NUM_PORTS);
      if (!any_req && bus.lrq_srdy[cand]) begin
        any_req = 1'b1;
        grant   = cand;
      end
    end
  end

  assign bus.eng_req_data = bus.lrq_data[32'(grant)*key_sz +: key_sz];
  assign bus.fli_data     = mask_src ? (bus.eng_rsp_data & ~port_bit(head)) : bus.eng_rsp_data;
  assign bus.err_orphan   = err_orphan_q;

  always_comb begin
    bus.eng_req_srdy = 1'b0;
    bus.lrq_drdy     = '0;
    bus.fli_srdy     = '0;
    bus.eng_rsp_drdy = 1'b1;
    tq_push          = 1'b0;
    tq_pop           = 1'b0;
    rr_d             = rr_q;
    err_orphan_d     = err_orphan_q;
    if (!reset) begin
      bus.eng_req_srdy    = any_req && !tq_full;
      bus.lrq_drdy[grant] = bus.eng_req_drdy && !tq_full;
      tq_push             = any_req && bus.eng_req_drdy && !tq_full;
      if (tq_push) rr_d = next_port(grant);
      if (!tq_empty) begin
        bus.fli_srdy[head] = bus.eng_rsp_srdy;
        bus.eng_rsp_drdy   = bus.fli_drdy[head];
        tq_pop             = bus.eng_rsp_srdy && bus.fli_drdy[head];
      end else if (bus.eng_rsp_srdy) begin
        err_orphan_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q         <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule

// File: tb/tb_fib_lookup_arb.sv
// Directed bench for fib_lookup_arb: 4 ports, 48-bit keys, depth-4 tag queue, mask_src=1.
module tb_fib_lookup_arb;
  import fib_lookup_arb_pkg::*;

  localparam int unsigned KW = 48;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  fib_lookup_arb_if #(.key_sz(KW)) bus ();

  fib_lookup_arb #(
    .key_sz     (KW),
    .tagq_depth (4),
    .mask_src   (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [KW-1:0] key_of(input int unsigned p);
    return 48'h0000_A0A0_0000 | KW'(p);
  endfunction

  // Next posedge, then 1 time unit past it so inputs change away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.lrq_srdy     = '0;
    bus.eng_req_drdy = 1'b1;
    bus.eng_rsp_srdy = 1'b0;
    bus.eng_rsp_data = '0;
    bus.fli_drdy     = 4'b1111;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) bus.lrq_data[p*KW +: KW] = key_of(p);
    idle_inputs();

    // Reset forces handshakes off even with traffic present.
    reset            = 1'b1;
    bus.lrq_srdy     = 4'b1111;
    bus.eng_rsp_srdy = 1'b1;
    step();
    settle();
    check("rst_req_srdy", 64'(bus.eng_req_srdy), 64'd0);
    check("rst_lrq_drdy", 64'(bus.lrq_drdy), 64'd0);
    check("rst_fli_srdy", 64'(bus.fli_srdy), 64'd0);
    check("rst_rsp_drdy", 64'(bus.eng_rsp_drdy), 64'd1);
    step();
    reset = 1'b0;
    idle_inputs();
    settle();
    check("rst_orphan", 64'(bus.err_orphan), 64'd0);
    check("rst_idle_req", 64'(bus.eng_req_srdy), 64'd0);

    // Single request from port 2.
    bus.lrq_data[2*KW +: KW] = 48'h0000_1111_2222;
    bus.lrq_srdy = 4'b0100;
    settle();
    check("single_req_srdy", 64'(bus.eng_req_srdy), 64'd1);
    check("single_req_data", 64'(bus.eng_req_data), 64'h0000_1111_2222);
    check("single_lrq_drdy", 64'(bus.lrq_drdy), 64'b0100);
    step();
    bus.lrq_srdy     = '0;
    bus.eng_rsp_srdy = 1'b1;
    bus.eng_rsp_data = 4'b1111;
    settle();
    check("single_fli_srdy", 64'(bus.fli_srdy), 64'b0100);
    check("single_fli_data", 64'(bus.fli_data), 64'b1011);
    check("single_rsp_drdy", 64'(bus.eng_rsp_drdy), 64'd1);
    step();
    bus.eng_rsp_srdy = 1'b0;
    bus.lrq_data[2*KW +: KW] = key_of(2);

    // Restart from rr=0 for the fairness sweep.
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Round-robin: all ports request, one response retires per cycle.
    for (int unsigned k = 0; k < 8; k++) begin
      bus.lrq_srdy     = 4'b1111;
      bus.eng_rsp_srdy = (k > 0);
      bus.eng_rsp_data = 4'b1111;
      settle();
      check($sformatf("rr_data_%0d", k), 64'(bus.eng_req_data), 64'(key_of(k % 4)));
      check($sformatf("rr_grant_%0d", k), 64'(bus.lrq_drdy), 64'(4'(1) << (k % 4)));
      if (k > 0) check($sformatf("rr_fli_%0d", k), 64'(bus.fli_srdy), 64'(4'(1) << ((k - 1) % 4)));
      step();
    end
    bus.lrq_srdy     = '0;
    bus.eng_rsp_srdy = 1'b1;
    settle();
    check("rr_drain_fli", 64'(bus.fli_srdy), 64'b1000);
    step();
    bus.eng_rsp_srdy = 1'b0;
    settle();
    check("rr_drained_orphan", 64'(bus.err_orphan), 64'd0);

    // Queue full: four accepted, then blocked; one pop frees exactly one slot.
    bus.lrq_srdy = 4'b1111;
    for (int unsigned k = 0; k < 4; k++) begin
      settle();
      check($sformatf("full_acc_%0d", k), 64'(bus.lrq_drdy), 64'(4'(1) << k));
      step();
    end
    settle();
    check("full_req_srdy", 64'(bus.eng_req_srdy), 64'd0);
    check("full_lrq_drdy", 64'(bus.lrq_drdy), 64'd0);
    step();
    settle();
    check("full_hold_srdy", 64'(bus.eng_req_srdy), 64'd0);
    bus.eng_rsp_srdy = 1'b1;
    bus.eng_rsp_data = 4'b1111;
    settle();
    check("full_pop_fli", 64'(bus.fli_srdy), 64'b0001);
    check("full_pop_blocked", 64'(bus.eng_req_srdy), 64'd0);
    step();
    bus.eng_rsp_srdy = 1'b0;
    settle();
    check("full_after_pop_srdy", 64'(bus.eng_req_srdy), 64'd1);
    check("full_after_pop_grant", 64'(bus.lrq_drdy), 64'b0001);
    step();
    bus.lrq_srdy     = '0;
    bus.eng_rsp_srdy = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      settle();
      check($sformatf("full_drain_fli_%0d", k), 64'(bus.fli_srdy), 64'(4'(1) << ((k + 1) % 4)));
      check($sformatf("full_drain_data_%0d", k), 64'(bus.fli_data), 64'(4'b1111 & ~(4'(1) << ((k + 1) % 4))));
      step();
    end
    bus.eng_rsp_srdy = 1'b0;

    // In-order steering under tap backpressure: requests 3,1,3 (rr is 1).
    bus.lrq_srdy = 4'b1000;
    settle();
    check("ord_grant0", 64'(bus.lrq_drdy), 64'b1000);
    step();
    bus.lrq_srdy = 4'b0010;
    settle();
    check("ord_grant1", 64'(bus.lrq_drdy), 64'b0010);
    step();
    bus.lrq_srdy = 4'b1000;
    settle();
    check("ord_grant2", 64'(bus.lrq_drdy), 64'b1000);
    step();
    bus.lrq_srdy     = '0;
    bus.eng_rsp_srdy = 1'b1;
    bus.eng_rsp_data = 4'b1001;
    bus.fli_drdy     = 4'b0111;
    for (int unsigned k = 0; k < 5; k++) begin
      settle();
      check($sformatf("ord_stall_drdy_%0d", k), 64'(bus.eng_rsp_drdy), 64'd0);
      check($sformatf("ord_stall_fli_%0d", k), 64'(bus.fli_srdy), 64'b1000);
      step();
    end
    bus.fli_drdy = 4'b1111;
    settle();
    check("ord_rsp0_fli", 64'(bus.fli_srdy), 64'b1000);
    check("ord_rsp0_data", 64'(bus.fli_data), 64'b0001);
    step();
    bus.eng_rsp_data = 4'b0110;
    settle();
    check("ord_rsp1_fli", 64'(bus.fli_srdy), 64'b0010);
    check("ord_rsp1_data", 64'(bus.fli_data), 64'b0100);
    step();
    bus.eng_rsp_data = 4'b1100;
    settle();
    check("ord_rsp2_fli", 64'(bus.fli_srdy), 64'b1000);
    check("ord_rsp2_data", 64'(bus.fli_data), 64'b0100);
    step();
    bus.eng_rsp_srdy = 1'b0;
    settle();
    check("ord_empty_drdy", 64'(bus.eng_rsp_drdy), 64'd1);
    check("ord_no_orphan", 64'(bus.err_orphan), 64'd0);

    // Orphan response with empty queue.
    bus.eng_rsp_srdy = 1'b1;
    bus.eng_rsp_data = 4'b1111;
    settle();
    check("orph_fli_srdy", 64'(bus.fli_srdy), 64'd0);
    check("orph_rsp_drdy", 64'(bus.eng_rsp_drdy), 64'd1);
    step();
    bus.eng_rsp_srdy = 1'b0;
    settle();
    check("orph_set", 64'(bus.err_orphan), 64'd1);
    step();
    step();
    check("orph_sticky", 64'(bus.err_orphan), 64'd1);

    // Reset with three lookups outstanding (rr is 0 here).
    bus.lrq_srdy = 4'b0111;
    for (int unsigned k = 0; k < 3; k++) begin
      settle();
      check($sformatf("mid_grant_%0d", k), 64'(bus.lrq_drdy), 64'(4'(1) << k));
      step();
    end
    reset            = 1'b1;
    bus.lrq_srdy     = 4'b1111;
    bus.eng_rsp_srdy = 1'b1;
    bus.fli_drdy     = 4'b0000;
    settle();
    check("mid_rst_req_srdy", 64'(bus.eng_req_srdy), 64'd0);
    check("mid_rst_lrq_drdy", 64'(bus.lrq_drdy), 64'd0);
    check("mid_rst_fli_srdy", 64'(bus.fli_srdy), 64'd0);
    check("mid_rst_rsp_drdy", 64'(bus.eng_rsp_drdy), 64'd1);
    step();
    reset = 1'b0;
    idle_inputs();
    settle();
    check("mid_post_orphan", 64'(bus.err_orphan), 64'd0);
    check("mid_post_empty", 64'(bus.eng_rsp_drdy), 64'd1);
    check("mid_post_req", 64'(bus.eng_req_srdy), 64'd0);
    bus.lrq_srdy = 4'b0100;
    settle();
    check("mid_new_grant", 64'(bus.lrq_drdy), 64'b0100);
    check("mid_new_data", 64'(bus.eng_req_data), 64'(key_of(2)));
    step();
    bus.lrq_srdy     = '0;
    bus.eng_rsp_srdy = 1'b1;
    bus.eng_rsp_data = 4'b1111;
    settle();
    check("mid_new_fli", 64'(bus.fli_srdy), 64'b0100);
    check("mid_new_fli_data", 64'(bus.fli_data), 64'b1011);
    step();
    bus.eng_rsp_srdy = 1'b0;
    settle();
    check("mid_final_orphan", 64'(bus.err_orphan), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
